// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - timer_sched FSM states, interval-timer register map and control bits
// S_STOP exists only when TIMER_SCHED_CANCEL_EN is defined.
package timer_sched_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR0,
      S_PERL,
      S_PERH,
      S_CTRL,
      S_WAIT,
`ifdef TIMER_SCHED_CANCEL_EN
      S_STOP,
`endif
      S_CLR1,
      S_DONE
   } state_e;

   localparam logic [2:0] TMR_STATUS  = 3'd0;
   localparam logic [2:0] TMR_CONTROL = 3'd1;
   localparam logic [2:0] TMR_PERIODL = 3'd2;
   localparam logic [2:0] TMR_PERIODH = 3'd3;

   localparam logic [15:0] CTRL_ITO   = 16'h0001;
   localparam logic [15:0] CTRL_CONT  = 16'h0002;
   localparam logic [15:0] CTRL_START = 16'h0004;
   localparam logic [15:0] CTRL_STOP  = 16'h0008;

endpackage

// File: rtl/timer_sched_rr_arb.sv
// rtl/timer_sched_rr_arb.sv - combinational round-robin pick of the first request at or after the pointer
module timer_sched_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic            valid_o,
   output logic [IDW-1:0]  idx_o,
   output logic [NREQ-1:0] onehot_o
);

   logic [IDW-1:0] cand;

   always_comb begin
      valid_o  = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(ptr_i) + k) % NREQ);
         if (!valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
      if (valid_o) onehot_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - round-robin sharing of one Avalon-MM interval timer among NREQ requesters
// Define TIMER_SCHED_CANCEL_EN to add per-requester cancel/aborted and the STOP write.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic [32*NREQ-1:0] period,
`ifdef TIMER_SCHED_CANCEL_EN
   input  logic [NREQ-1:0]   cancel,
   output logic [NREQ-1:0]   aborted,
`endif
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [2:0]        tmr_address,
   output logic              tmr_chipselect,
   output logic              tmr_write_n,
   output logic [15:0]       tmr_writedata,
   input  logic              tmr_irq
);

   state_e            state_q;
   logic [IDW-1:0]    rr_q, idx_q;
   logic [31:0]       per_q;
   logic [NREQ-1:0]   grant_q, done_q;
   logic              busy_q, cs_q, wn_q;
   logic [2:0]        addr_q;
   logic [15:0]       wdata_q;
`ifdef TIMER_SCHED_CANCEL_EN
   logic [NREQ-1:0]   aborted_q;
   logic              cancelled_q;
`endif

   logic              arb_valid;
   logic [IDW-1:0]    arb_idx;
   logic [NREQ-1:0]   arb_onehot;
   logic [31:0]       per_a [NREQ];
   logic [31:0]       per_sel;

   for (genvar i = 0; i < NREQ; i++) begin : g_per
      assign per_a[i] = period[32*i +: 32];
   end
   assign per_sel = per_a[arb_idx];

   timer_sched_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i    (req),
      .ptr_i    (rr_q),
      .valid_o  (arb_valid),
      .idx_o    (arb_idx),
      .onehot_o (arb_onehot)
   );

   // Bus values are registered on entry to a state, so each write is visible during that state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         idx_q   <= '0;
         per_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         {cs_q, wn_q, addr_q, wdata_q} <= {1'b0, 1'b1, TMR_STATUS, 16'h0000};
`ifdef TIMER_SCHED_CANCEL_EN
         aborted_q   <= '0;
         cancelled_q <= 1'b0;
`endif
      end else begin
         {cs_q, wn_q, addr_q, wdata_q} <= {1'b0, 1'b1, TMR_STATUS, 16'h0000};
         done_q <= '0;
`ifdef TIMER_SCHED_CANCEL_EN
         aborted_q <= '0;
`endif
         if (state_q != S_IDLE && int'(idx_q) >= NREQ) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: if (arb_valid) begin
                  idx_q   <= arb_idx;
                  per_q   <= (per_sel == 32'd0) ? 32'd1 : per_sel;
                  grant_q <= arb_onehot;
                  busy_q  <= 1'b1;
                  state_q <= S_CLR0;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_STATUS, 16'h0000};
               end
               S_CLR0: begin
                  state_q <= S_PERL;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_PERIODL, per_q[15:0]};
               end
               S_PERL: begin
                  state_q <= S_PERH;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_PERIODH, per_q[31:16]};
               end
               S_PERH: begin
                  state_q <= S_CTRL;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_CONTROL, CTRL_START | CTRL_ITO};
               end
               S_CTRL: state_q <= S_WAIT;
               // A completed timeout takes priority over a same-cycle cancel.
               S_WAIT: if (tmr_irq) begin
                  state_q <= S_CLR1;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_STATUS, 16'h0000};
               end
`ifdef TIMER_SCHED_CANCEL_EN
               else if (cancel[idx_q]) begin
                  state_q     <= S_STOP;
                  cancelled_q <= 1'b1;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_CONTROL, CTRL_STOP};
               end
               S_STOP: begin
                  state_q <= S_CLR1;
                  {cs_q, wn_q, addr_q, wdata_q} <= {1'b1, 1'b0, TMR_STATUS, 16'h0000};
               end
`endif
               S_CLR1: begin
                  state_q <= S_DONE;
                  grant_q <= '0;
                  rr_q    <= (int'(idx_q) == NREQ - 1) ? '0 : idx_q + IDW'(1);
`ifdef TIMER_SCHED_CANCEL_EN
                  if (cancelled_q) aborted_q <= grant_q;
                  else             done_q    <= grant_q;
`else
                  done_q  <= grant_q;
`endif
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
                  cancelled_q <= 1'b0;
`endif
               end
               default: begin
                  state_q <= S_IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
                  cancelled_q <= 1'b0;
`endif
               end
            endcase
         end
      end
   end

   assign grant          = grant_q;
   assign done           = done_q;
   assign busy           = busy_q;
   assign tmr_address    = addr_q;
   assign tmr_chipselect = cs_q;
   assign tmr_write_n    = wn_q;
   assign tmr_writedata  = wdata_q;
`ifdef TIMER_SCHED_CANCEL_EN
   assign aborted        = aborted_q;
`endif

endmodule

// File: tb/tb_timer_sched.sv
// tb/tb_timer_sched.sv - directed self-checking bench for timer_sched with a behavioural interval timer
module tb_timer_sched;

   localparam int NREQ = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req;
   logic [32*NREQ-1:0] period;
   logic [NREQ-1:0]   grant, done, aborted;
   logic              busy, tmr_chipselect, tmr_write_n, tmr_irq;
   logic [2:0]        tmr_address;
   logic [15:0]       tmr_writedata;
`ifdef TIMER_SCHED_CANCEL_EN
   logic [NREQ-1:0]   cancel;
`else
   assign aborted = '0;
`endif

   timer_sched #(.NREQ(NREQ), .IDW(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req            (req),
      .period         (period),
`ifdef TIMER_SCHED_CANCEL_EN
      .cancel         (cancel),
      .aborted        (aborted),
`endif
      .grant          (grant),
      .done           (done),
      .busy           (busy),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .tmr_irq        (tmr_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Interval timer: irq rises period+1 cycles after START, cleared by a status write.
   logic [15:0] m_pl, m_ph;
   logic [31:0] m_cnt;
   logic        m_run, m_irq, irq_kick;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_irq <= 1'b0; m_run <= 1'b0; m_cnt <= '0; m_pl <= '0; m_ph <= '0;
      end else begin
         if (irq_kick) m_irq <= 1'b1;
         if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
               3'd0: m_irq <= 1'b0;
               3'd2: m_pl <= tmr_writedata;
               3'd3: m_ph <= tmr_writedata;
               3'd1: begin
                  if (tmr_writedata[2]) begin m_run <= 1'b1; m_cnt <= {m_ph, m_pl}; end
                  if (tmr_writedata[3]) m_run <= 1'b0;
               end
               default: ;
            endcase
         end else if (m_run) begin
            if (m_cnt == 0) begin m_irq <= 1'b1; m_run <= 1'b0; end
            else m_cnt <= m_cnt - 1;
         end
      end
   end
   assign tmr_irq = m_irq;

   logic [2:0]  wa[$];
   logic [15:0] wd[$];
   int          wc[$];
   always @(negedge clk) begin
      if (tmr_chipselect && !tmr_write_n) begin
         wa.push_back(tmr_address);
         wd.push_back(tmr_writedata);
         wc.push_back(cyc);
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input string tag, output int idx, output int c);
      int k = 0;
      idx = -1;
      while (grant === '0 && k < 50) begin @(negedge clk); k++; end
      chk({tag, "_granted"}, 32'(grant !== '0), 32'd1);
      for (int i = 0; i < NREQ; i++) if (grant[i]) idx = i;
      c = cyc;
   endtask

   task automatic wait_evt(input string tag, input int maxc, output int c);
      int k = 0;
      while ((done | aborted) === '0 && k < maxc) begin @(negedge clk); k++; end
      chk({tag, "_completed"}, 32'((done | aborted) !== '0), 32'd1);
      c = cyc;
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wc.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int g, gc, dc, last_dc;

   initial begin
      reset_n = 1'b0; req = '0; period = '0; irq_kick = 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
      cancel = '0;
`endif
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_cs", 32'(tmr_chipselect), 32'h0);
      chk("rst_wn", 32'(tmr_write_n), 32'h1);
      chk("rst_addr", 32'(tmr_address), 32'h0);
      chk("rst_wdata", 32'(tmr_writedata), 32'h0);
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk);

      // Single request; req dropped after grant must not abort the service.
      clear_log();
      period[32*1 +: 32] = 32'h0000C34F; req = 4'b0010;
      wait_grant("single", g, gc);
      chk("single_grant", 32'(grant), 32'h2);
      chk("single_busy", 32'(busy), 32'h1);
      req = '0;
      wait_evt("single", 60000, dc);
      chk("single_done", 32'(done), 32'h2);
      chk("single_grant_drop", 32'(grant), 32'h0);
      chk("single_nwr", 32'(wa.size()), 32'd5);
      if (wa.size() == 5) begin
         chk("single_w0", {13'd0, wa[0], wd[0]}, {13'd0, 3'd0, 16'h0000});
         chk("single_w1", {13'd0, wa[1], wd[1]}, {13'd0, 3'd2, 16'hC34F});
         chk("single_w2", {13'd0, wa[2], wd[2]}, {13'd0, 3'd3, 16'h0000});
         chk("single_w3", {13'd0, wa[3], wd[3]}, {13'd0, 3'd1, 16'h0005});
         chk("single_w4", {13'd0, wa[4], wd[4]}, {13'd0, 3'd0, 16'h0000});
         chk("single_consec", 32'(wc[3] - wc[0]), 32'd3);
         chk("single_irq_lat", 32'(dc - wc[3]), 32'd50003);
      end
      @(negedge clk);
      chk("single_done_pulse", 32'(done), 32'h0);
      @(negedge clk);
      chk("single_idle_busy", 32'(busy), 32'h0);

      // Contention from rr=0 with all requests held.
      reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
      for (int i = 0; i < NREQ; i++) period[32*i +: 32] = 32'd2;
      req = 4'b1111;
      last_dc = 0;
      for (int s = 0; s < 5; s++) begin
         wait_grant("rr", g, gc);
         chk($sformatf("rr_order%0d", s), 32'(g), 32'(s % NREQ));
         if (s > 0) chk($sformatf("rr_gap%0d", s), 32'(gc - last_dc >= 2), 32'd1);
         wait_evt("rr", 200, dc);
         chk($sformatf("rr_done%0d", s), 32'(done), 32'(1 << (s % NREQ)));
         last_dc = dc;
         if (s == 4) req = '0;
      end

      // Latched period is immune to a bus change after grant.
      reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
      clear_log();
      period[31:0] = 32'h10; req = 4'b0001;
      wait_grant("perchg", g, gc);
      period[31:0] = 32'h20; req = '0;
      wait_evt("perchg", 200, dc);
      if (wa.size() >= 3) begin
         chk("perchg_perl", {13'd0, wa[1], wd[1]}, {13'd0, 3'd2, 16'h0010});
         chk("perchg_perh", {13'd0, wa[2], wd[2]}, {13'd0, 3'd3, 16'h0000});
      end else chk("perchg_nwr", 32'(wa.size()), 32'd5);
      repeat (2) @(negedge clk);

      // Stale irq pending before the request is cleared by CLR0.
      irq_kick = 1'b1; @(negedge clk); irq_kick = 1'b0;
      chk("stale_irq_set", 32'(tmr_irq), 32'h1);
      clear_log();
      period[32*2 +: 32] = 32'd4; req = 4'b0100;
      wait_grant("stale", g, gc);
      chk("stale_idx", 32'(g), 32'd2);
      req = '0;
      wait_evt("stale", 200, dc);
      chk("stale_done", 32'(done), 32'h4);
      if (wa.size() == 5) begin
         chk("stale_first_clr", {13'd0, wa[0], wd[0]}, {13'd0, 3'd0, 16'h0000});
         chk("stale_irq_lat", 32'(dc - wc[3]), 32'd8);
      end else chk("stale_nwr", 32'(wa.size()), 32'd5);
      repeat (2) @(negedge clk);

      // Async reset while waiting; rr must restart at 0.
      period[32*3 +: 32] = 32'd1000; req = 4'b1000;
      wait_grant("arst", g, gc);
      chk("arst_idx", 32'(g), 32'd3);
      repeat (6) @(negedge clk);
      chk("arst_in_wait", 32'(busy), 32'h1);
      req = 4'b1010; period[32*1 +: 32] = 32'd0;
      #2 reset_n = 1'b0;
      #1;
      chk("arst_grant", 32'(grant), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_bus", {28'd0, tmr_chipselect, tmr_write_n, 2'b00}, {28'd0, 1'b0, 1'b1, 2'b00});
      @(negedge clk); reset_n = 1'b1;
      clear_log();
      wait_grant("arst_restart", g, gc);
      chk("arst_restart_idx", 32'(g), 32'd1);
      req = '0;
      wait_evt("arst_restart", 200, dc);
      if (wa.size() == 5) begin
         chk("arst_restart_clr0", {13'd0, wa[0], wd[0]}, {13'd0, 3'd0, 16'h0000});
         chk("zero_period_perl", {13'd0, wa[1], wd[1]}, {13'd0, 3'd2, 16'h0001});
      end else chk("arst_restart_nwr", 32'(wa.size()), 32'd5);
      repeat (2) @(negedge clk);

`ifdef TIMER_SCHED_CANCEL_EN
      clear_log();
      period[32*2 +: 32] = 32'd100; req = 4'b0100;
      wait_grant("cancel", g, gc);
      req = '0;
      repeat (6) @(negedge clk);
      cancel = 4'b0100; @(negedge clk); cancel = '0;
      wait_evt("cancel", 200, dc);
      chk("cancel_aborted", 32'(aborted), 32'h4);
      chk("cancel_no_done", 32'(done), 32'h0);
      if (wa.size() == 6) begin
         chk("cancel_stop", {13'd0, wa[4], wd[4]}, {13'd0, 3'd1, 16'h0008});
         chk("cancel_clr1", {13'd0, wa[5], wd[5]}, {13'd0, 3'd0, 16'h0000});
      end else chk("cancel_nwr", 32'(wa.size()), 32'd6);
      repeat (2) @(negedge clk);

      req = 4'b0100;
      wait_grant("irqwin", g, gc);
      req = '0;
      repeat (6) @(negedge clk);
      irq_kick = 1'b1; @(negedge clk); irq_kick = 1'b0;
      cancel = 4'b0100; @(negedge clk); cancel = '0;
      wait_evt("irqwin", 200, dc);
      chk("irqwin_done", 32'(done), 32'h4);
      chk("irqwin_no_abort", 32'(aborted), 32'h0);
      repeat (2) @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
